csr_timer: RTL and testbench

//   Timer/counter CSR group beside the core CSR file: owns TID (0x40), TCFG (0x41), TVAL (0x42), TICLR (0x44).

---
 rtl/csr_timer.sv | 106 ++++++++++
 tb/tb_csr_timer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_timer.sv
// Timer/counter CSR group (TID, TCFG, TVAL, TICLR) plus the 64-bit stable counter.
// Shares the CSR file's write bus; rdata and csr_hit are purely combinational.
module csr_timer #(
   parameter logic [31:0] CORE_ID = 32'h0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [13:0] csr_num,
   input  logic        we,
   input  logic [31:0] wdata,
   input  logic [31:0] wmask,
   output logic [31:0] rdata,
   output logic        csr_hit,
   output logic        timer_int,
   output logic [63:0] stable_cnt,
   output logic [31:0] counter_id
);

   localparam logic [13:0] ADDR_TID   = 14'h40;
   localparam logic [13:0] ADDR_TCFG  = 14'h41;
   localparam logic [13:0] ADDR_TVAL  = 14'h42;
   localparam logic [13:0] ADDR_TICLR = 14'h44;

   logic [31:0] r_tid;
   logic [31:0] r_tcfg;
   logic [31:0] r_tval;
   logic        r_timer_int;
   logic [63:0] r_stable_cnt;

   logic        w_sel_tid;
   logic        w_sel_tcfg;
   logic        w_sel_tval;
   logic        w_sel_ticlr;
   logic        w_tid_wr;
   logic        w_tcfg_wr;
   logic [31:0] w_tid_new;
   logic [31:0] w_tcfg_new;
   logic [31:0] w_tval_next;
   logic        w_ti_set;
   logic        w_ti_clr;

   assign w_sel_tid   = (csr_num == ADDR_TID);
   assign w_sel_tcfg  = (csr_num == ADDR_TCFG);
   assign w_sel_tval  = (csr_num == ADDR_TVAL);
   assign w_sel_ticlr = (csr_num == ADDR_TICLR);
   assign csr_hit     = w_sel_tid | w_sel_tcfg | w_sel_tval | w_sel_ticlr;

   assign w_tid_wr   = we & w_sel_tid;
   assign w_tcfg_wr  = we & w_sel_tcfg;
   assign w_tid_new  = (wmask & wdata) | (~wmask & r_tid);
   assign w_tcfg_new = (wmask & wdata) | (~wmask & r_tcfg);

   assign w_ti_set = r_tcfg[0] & (r_tval == 32'd0);
   assign w_ti_clr = we & w_sel_ticlr & wmask[0] & wdata[0];

   // A TCFG write decides the enable for this cycle: En=1 reloads, En=0 freezes TVAL.
   always_comb begin
      w_tval_next = r_tval;
      if (w_tcfg_wr) begin
         if (w_tcfg_new[0])
            w_tval_next = {w_tcfg_new[31:2], 2'b00};
      end else if (r_tcfg[0] && (r_tval != 32'hFFFF_FFFF)) begin
         if ((r_tval == 32'd0) && r_tcfg[1])
            w_tval_next = {r_tcfg[31:2], 2'b00};
         else
            w_tval_next = r_tval - 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_tid        <= CORE_ID;
         r_tcfg       <= 32'd0;
         r_tval       <= 32'hFFFF_FFFF;
         r_timer_int  <= 1'b0;
         r_stable_cnt <= 64'd0;
      end else begin
         r_stable_cnt <= r_stable_cnt + 64'd1;
         r_tval       <= w_tval_next;
         if (w_tid_wr)
            r_tid <= w_tid_new;
         if (w_tcfg_wr)
            r_tcfg <= w_tcfg_new;
         // An expiry in the same cycle as a clear keeps the interrupt pending.
         if (w_ti_set)
            r_timer_int <= 1'b1;
         else if (w_ti_clr)
            r_timer_int <= 1'b0;
      end
   end

   always_comb begin
      rdata = 32'd0;
      case (1'b1)
         w_sel_tid:  rdata = r_tid;
         w_sel_tcfg: rdata = r_tcfg;
         w_sel_tval: rdata = r_tval;
         default:    rdata = 32'd0;
      endcase
   end

   assign timer_int  = r_timer_int;
   assign stable_cnt = r_stable_cnt;
   assign counter_id = r_tid;

endmodule

// File: tb/tb_csr_timer.sv
// Scoreboard bench for csr_timer: expectations are queued when stimulus is applied
// and compared after the following clock edge.
module tb_csr_timer;

   localparam logic [31:0] CORE_ID = 32'h0000_0007;

   localparam int K_RD  = 0;
   localparam int K_HIT = 1;
   localparam int K_TI  = 2;
   localparam int K_CNT = 3;
   localparam int K_ID  = 4;

   logic        clk;
   logic        resetn;
   logic [13:0] csr_num;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] wmask;
   logic [31:0] rdata;
   logic        csr_hit;
   logic        timer_int;
   logic [63:0] stable_cnt;
   logic [31:0] counter_id;

   typedef struct {
      string       tag;
      int          kind;
      logic [13:0] num;
      logic [63:0] exp;
   } expT;

   expT sbQ[$];
   int  checkCount = 0;
   int  errorCount = 0;

   csr_timer #(.CORE_ID(CORE_ID)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .csr_num    (csr_num),
      .we         (we),
      .wdata      (wdata),
      .wmask      (wmask),
      .rdata      (rdata),
      .csr_hit    (csr_hit),
      .timer_int  (timer_int),
      .stable_cnt (stable_cnt),
      .counter_id (counter_id)
   );

   initial begin
      clk = 1'b0;
      forever #20 clk = ~clk;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic pushExp(input string tag, input int kind, input logic [13:0] num,
                          input logic [63:0] exp);
      expT e;
      e.tag  = tag;
      e.kind = kind;
      e.num  = num;
      e.exp  = exp;
      sbQ.push_back(e);
   endtask

   task automatic pushTval(input string tag, input logic [31:0] v);
      pushExp(tag, K_RD, 14'h42, {32'd0, v});
   endtask

   task automatic pushTi(input string tag, input logic v);
      pushExp(tag, K_TI, 14'h0, {63'd0, v});
   endtask

   task automatic applyStimulus(input logic [13:0] n, input logic w,
                                input logic [31:0] d, input logic [31:0] m);
      csr_num = n;
      we      = w;
      wdata   = d;
      wmask   = m;
   endtask

   // Each queued read parks the bus on its address with we low before sampling.
   task automatic stepClock();
      expT e;
      @(posedge clk);
      #1;
      while (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         csr_num = e.num;
         we      = 1'b0;
         #1;
         case (e.kind)
            K_RD:    checkOutput(e.tag, {32'd0, rdata}, e.exp);
            K_HIT:   checkOutput(e.tag, {63'd0, csr_hit}, e.exp);
            K_TI:    checkOutput(e.tag, {63'd0, timer_int}, e.exp);
            K_CNT:   checkOutput(e.tag, stable_cnt, e.exp);
            default: checkOutput(e.tag, {32'd0, counter_id}, e.exp);
         endcase
      end
   endtask

   initial begin
      resetn = 1'b0;
      applyStimulus(14'h0, 1'b0, 32'd0, 32'd0);

      // Reset state and stable counter after release
      pushTval("rst_tval", 32'hFFFF_FFFF);
      pushExp("rst_tcfg", K_RD, 14'h41, 64'd0);
      pushTi("rst_ti", 1'b0);
      pushExp("rst_cnt", K_CNT, 14'h0, 64'd0);
      pushExp("rst_id", K_ID, 14'h0, {32'd0, CORE_ID});
      stepClock();
      resetn = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         if (i == 10) begin
            pushExp("cnt10", K_CNT, 14'h0, 64'd10);
            pushTval("idle_tval", 32'hFFFF_FFFF);
            pushTi("idle_ti", 1'b0);
            pushExp("idle_tid", K_RD, 14'h40, {32'd0, CORE_ID});
         end
         stepClock();
      end

      pushExp("hit40", K_HIT, 14'h40, 64'd1);
      pushExp("hit41", K_HIT, 14'h41, 64'd1);
      pushExp("hit42", K_HIT, 14'h42, 64'd1);
      pushExp("hit44", K_HIT, 14'h44, 64'd1);
      stepClock();
      pushExp("hit43", K_HIT, 14'h43, 64'd0);
      pushExp("hit45", K_HIT, 14'h45, 64'd0);
      pushExp("hit2040", K_HIT, 14'h2040, 64'd0);
      pushExp("rd43", K_RD, 14'h43, 64'd0);
      pushExp("rd_ticlr", K_RD, 14'h44, 64'd0);
      stepClock();

      // Masked TID write, ignored TVAL write, write outside the group
      applyStimulus(14'h40, 1'b1, 32'hABCD_1234, 32'hFFFF_0000);
      pushExp("tid_masked", K_RD, 14'h40, 64'h0000_0000_ABCD_0007);
      pushExp("cntid_masked", K_ID, 14'h0, 64'h0000_0000_ABCD_0007);
      stepClock();
      applyStimulus(14'h42, 1'b1, 32'h0000_1234, 32'hFFFF_FFFF);
      pushTval("tval_ro", 32'hFFFF_FFFF);
      stepClock();
      applyStimulus(14'h43, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      pushExp("oob_tcfg", K_RD, 14'h41, 64'd0);
      pushExp("oob_tid", K_RD, 14'h40, 64'h0000_0000_ABCD_0007);
      pushTi("oob_ti", 1'b0);
      stepClock();

      // One-shot, InitVal=4
      applyStimulus(14'h41, 1'b1, 32'h0000_0011, 32'hFFFF_FFFF);
      #1;
      checkOutput("rd_old_tcfg", {32'd0, rdata}, 64'd0);
      pushTval("os_load", 32'd16);
      pushExp("os_tcfg", K_RD, 14'h41, 64'h11);
      pushTi("os_ti_load", 1'b0);
      stepClock();
      for (int k = 15; k >= 0; k--) begin
         pushTval($sformatf("os_tval%0d", k), k[31:0]);
         pushTi($sformatf("os_ti%0d", k), 1'b0);
         stepClock();
      end
      for (int i = 0; i < 3; i++) begin
         pushTval($sformatf("os_hold%0d", i), 32'hFFFF_FFFF);
         pushTi($sformatf("os_ti_hold%0d", i), 1'b1);
         stepClock();
      end

      // Periodic, InitVal=2
      applyStimulus(14'h44, 1'b1, 32'h1, 32'hFFFF_FFFF);
      pushTi("clr_before_per", 1'b0);
      stepClock();
      applyStimulus(14'h41, 1'b1, 32'h0000_000B, 32'hFFFF_FFFF);
      pushTval("per_load", 32'd8);
      pushExp("per_tcfg", K_RD, 14'h41, 64'hB);
      stepClock();
      for (int k = 7; k >= 0; k--) begin
         pushTval($sformatf("per_a%0d", k), k[31:0]);
         pushTi($sformatf("per_a_ti%0d", k), 1'b0);
         stepClock();
      end
      pushTval("per_reload1", 32'd8);
      pushTi("per_ti_exp1", 1'b1);
      stepClock();
      pushTval("per_b7", 32'd7);
      pushTi("per_b_ti7", 1'b1);
      stepClock();
      applyStimulus(14'h44, 1'b1, 32'h1, 32'h0);
      pushTval("per_b6", 32'd6);
      pushTi("ticlr_masked_off", 1'b1);
      stepClock();
      applyStimulus(14'h44, 1'b1, 32'h2, 32'hFFFF_FFFF);
      pushTval("per_b5", 32'd5);
      pushTi("ticlr_bit1", 1'b1);
      stepClock();
      applyStimulus(14'h44, 1'b1, 32'h1, 32'hFFFF_FFFF);
      pushTval("per_b4", 32'd4);
      pushTi("ticlr_clear", 1'b0);
      stepClock();
      for (int k = 3; k >= 0; k--) begin
         pushTval($sformatf("per_b%0d", k), k[31:0]);
         pushTi($sformatf("per_b_ti%0d", k), 1'b0);
         stepClock();
      end
      pushTval("per_reload2", 32'd8);
      pushTi("per_ti_exp2", 1'b1);
      stepClock();

      // Clear in the same cycle as expiry: set wins
      applyStimulus(14'h44, 1'b1, 32'h1, 32'hFFFF_FFFF);
      pushTval("sw_7", 32'd7);
      pushTi("sw_clr", 1'b0);
      stepClock();
      for (int k = 6; k >= 0; k--) begin
         pushTval($sformatf("sw_%0d", k), k[31:0]);
         pushTi($sformatf("sw_ti%0d", k), 1'b0);
         stepClock();
      end
      applyStimulus(14'h44, 1'b1, 32'h1, 32'hFFFF_FFFF);
      pushTval("sw_reload", 32'd8);
      pushTi("set_wins", 1'b1);
      stepClock();

      // Freeze with En=0, then masked restart
      applyStimulus(14'h44, 1'b1, 32'h1, 32'hFFFF_FFFF);
      pushTval("fr_7", 32'd7);
      pushTi("fr_clr", 1'b0);
      stepClock();
      applyStimulus(14'h41, 1'b1, 32'h0, 32'h1);
      pushTval("fr_freeze", 32'd7);
      pushExp("fr_tcfg", K_RD, 14'h41, 64'hA);
      pushTi("fr_ti", 1'b0);
      stepClock();
      for (int i = 0; i < 3; i++) begin
         pushTval($sformatf("fr_hold%0d", i), 32'd7);
         pushTi($sformatf("fr_ti_hold%0d", i), 1'b0);
         stepClock();
      end
      applyStimulus(14'h41, 1'b1, 32'h1, 32'h1);
      pushTval("fr_restart", 32'd8);
      pushExp("fr_tcfg_en", K_RD, 14'h41, 64'hB);
      stepClock();
      for (int k = 7; k >= 0; k--) begin
         pushTval($sformatf("rs_%0d", k), k[31:0]);
         stepClock();
      end
      pushTval("rs_reload", 32'd8);
      pushTi("rs_ti", 1'b1);
      stepClock();

      // Stable counter wrap
      force dut.r_stable_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
      #1;
      release dut.r_stable_cnt;
      pushExp("cnt_max", K_CNT, 14'h0, 64'hFFFF_FFFF_FFFF_FFFF);
      stepClock();
      pushExp("cnt_wrap", K_CNT, 14'h0, 64'd0);
      stepClock();

      // Reset during active count with a pending interrupt and a concurrent write
      resetn = 1'b0;
      applyStimulus(14'h41, 1'b1, 32'h0000_0011, 32'hFFFF_FFFF);
      pushTval("mr_tval", 32'hFFFF_FFFF);
      pushExp("mr_tcfg", K_RD, 14'h41, 64'd0);
      pushTi("mr_ti", 1'b0);
      pushExp("mr_cnt", K_CNT, 14'h0, 64'd0);
      pushExp("mr_id", K_ID, 14'h0, {32'd0, CORE_ID});
      stepClock();
      resetn = 1'b1;
      pushExp("mr_cnt1", K_CNT, 14'h0, 64'd1);
      pushTval("mr_stop1", 32'hFFFF_FFFF);
      stepClock();
      pushTval("mr_stop2", 32'hFFFF_FFFF);
      pushTi("mr_ti2", 1'b0);
      stepClock();

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
